floor_request_scheduler: RTL and testbench



---
 rtl/elev_pkg.sv | 28 ++
 rtl/next_floor_sel.sv | 70 +++++++
 rtl/floor_request_scheduler.sv | 130 +++++++++++++
 tb/tb_floor_request_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator scheduler.
//   NFLOORS / FLOOR_W : floor count and floor-index width
//   CNT_W             : door-dwell counter width
//   sched_state_t     : scheduler FSM states
//   dir_t             : travel direction
//   floor_onehot()    : floor index to one-hot request mask
package elev_pkg;

  localparam int unsigned NFLOORS = 4;
  localparam int unsigned FLOOR_W = 2;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2
  } sched_state_t;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_t;

  function automatic logic [NFLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    floor_onehot = NFLOORS'(1) << f;
  endfunction

endpackage

// File: rtl/next_floor_sel.sv
// Combinational SCAN target selector.
//   pending : outstanding request vector
//   cf      : current floor
//   dir     : current travel direction
//   target  : next floor to serve
//   new_dir : direction to adopt when heading to target
//   found   : any request outstanding
module next_floor_sel
  import elev_pkg::*;
(
  input  logic [NFLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0] cf,
  input  dir_t               dir,
  output logic [FLOOR_W-1:0] target,
  output dir_t               new_dir,
  output logic               found
);

  logic               above_found;
  logic               below_found;
  logic [FLOOR_W-1:0] above_idx;
  logic [FLOOR_W-1:0] below_idx;

  // Nearest pending floor strictly above and strictly below cf.
  always_comb begin
    above_found = 1'b0;
    below_found = 1'b0;
    above_idx   = '0;
    below_idx   = '0;
    // Scan top-down so the last hit is the lowest floor above cf.
    for (int i = int'(NFLOORS) - 1; i >= 0; i--) begin
      if ((i > int'(cf)) && pending[i]) begin
        above_found = 1'b1;
        above_idx   = FLOOR_W'(i);
      end
    end
    // Scan bottom-up so the last hit is the highest floor below cf.
    for (int i = 0; i < int'(NFLOORS); i++) begin
      if ((i < int'(cf)) && pending[i]) begin
        below_found = 1'b1;
        below_idx   = FLOOR_W'(i);
      end
    end
  end

  // Keep direction while work remains ahead; otherwise reverse.
  always_comb begin
    target  = cf;
    new_dir = dir;
    found   = |pending;
    if (dir == UP) begin
      if (above_found) begin
        target  = above_idx;
        new_dir = UP;
      end else if (below_found) begin
        target  = below_idx;
        new_dir = DOWN;
      end
    end else begin
      if (below_found) begin
        target  = below_idx;
        new_dir = DOWN;
      end else if (above_found) begin
        target  = above_idx;
        new_dir = UP;
      end
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches floor calls, picks the next target with a SCAN policy, drives it
// to the elevator FSM, and holds the door open for DWELL_CYCLES on arrival.
//   clk, rst  : clock, synchronous active-high reset
//   req       : call buttons, one per floor (level-sampled)
//   cf        : current floor from the elevator FSM
//   floor     : registered target floor
//   door_open : high throughout the dwell interval
//   busy      : FSM not idle or requests outstanding
//   pending   : registered outstanding-request vector
//   dir       : travel direction, 1 = up
module floor_request_scheduler
  import elev_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] req,
  input  logic [FLOOR_W-1:0] cf,
  output logic [FLOOR_W-1:0] floor,
  output logic               door_open,
  output logic               busy,
  output logic [NFLOORS-1:0] pending,
  output logic               dir
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  sched_state_t       state_q, state_d;
  logic [NFLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  dir_t               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               door_open_q, door_open_d;
  logic               busy_q, busy_d;

  logic [NFLOORS-1:0] clr_mask;
  logic [FLOOR_W-1:0] sel_target;
  dir_t               sel_dir;
  logic               sel_found;
  logic               between;

  next_floor_sel u_sel (
    .pending (pending_q),
    .cf      (cf),
    .dir     (dir_q),
    .target  (sel_target),
    .new_dir (sel_dir),
    .found   (sel_found)
  );

  // A nearer request strictly between cf and the current target, ahead of travel.
  always_comb begin
    if (dir_q == UP) begin
      between = (sel_target > cf) && (sel_target < floor_q);
    end else begin
      between = (sel_target < cf) && (sel_target > floor_q);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;

    // The open door absorbs its own floor's button, even if held.
    clr_mask  = (state_q == DWELL) ? floor_onehot(cf) : '0;
    pending_d = (pending_q | req) & ~clr_mask;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          floor_d = sel_target;
          dir_d   = sel_dir;
          state_d = MOVE;
        end else begin
          floor_d = cf;
        end
      end
      MOVE: begin
        if (cf == floor_q) begin
          state_d = DWELL;
          cnt_d   = DWELL_LOAD;
        end else if (sel_found && (sel_dir == dir_q) && between) begin
          floor_d = sel_target;
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    door_open_d = (state_d == DWELL);
    busy_d      = (state_d != IDLE) || (|pending_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      floor_q     <= '0;
      dir_q       <= UP;
      cnt_q       <= '0;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      door_open_q <= door_open_d;
      busy_q      <= busy_d;
    end
  end

  assign floor     = floor_q;
  assign door_open = door_open_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign dir       = dir_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
module tb_floor_request_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] cf;
  logic [1:0] floor;
  logic       door_open;
  logic       busy;
  logic [3:0] pending;
  logic       dir;

  int tests;
  int fails;

  floor_request_scheduler #(.DWELL_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .cf        (cf),
    .floor     (floor),
    .door_open (door_open),
    .busy      (busy),
    .pending   (pending),
    .dir       (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [1:0] cf;
    logic [1:0] floor;
    logic       door;
    logic       busy;
    logic [3:0] pend;
    logic       dir;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [1:0] c,
                              input logic [1:0] fl, input logic d, input logic b,
                              input logic [3:0] p, input logic dr);
    vec_t v;
    v.rst = r; v.req = rq; v.cf = c; v.floor = fl;
    v.door = d; v.busy = b; v.pend = p; v.dir = dr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, floor, door_open, busy, pending, dir};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dwell_cnt;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req = 4'b0;
    cf  = 2'd0;

    //          rst req      cf    floor door busy pend     dir
    vq.push_back(mk(1, 4'b1111, 2'd0, 2'd0, 0, 0, 4'b0000, 1));
    vq.push_back(mk(1, 4'b1111, 2'd0, 2'd0, 0, 0, 4'b0000, 1));
    vq.push_back(mk(0, 4'b1000, 2'd0, 2'd0, 0, 1, 4'b1000, 1));
    vq.push_back(mk(0, 4'b0000, 2'd0, 2'd3, 0, 1, 4'b1000, 1));
    vq.push_back(mk(0, 4'b0000, 2'd1, 2'd3, 0, 1, 4'b1000, 1));
    vq.push_back(mk(0, 4'b0000, 2'd2, 2'd3, 0, 1, 4'b1000, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 1, 1, 4'b1000, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 1, 1, 4'b0000, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 1, 1, 4'b0000, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 1, 1, 4'b0000, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 0, 0, 4'b0000, 1));
    // SCAN: from floor 1 going up with calls at 0 and 3
    vq.push_back(mk(0, 4'b1001, 2'd1, 2'd1, 0, 1, 4'b1001, 1));
    vq.push_back(mk(0, 4'b0000, 2'd1, 2'd3, 0, 1, 4'b1001, 1));
    vq.push_back(mk(0, 4'b0000, 2'd2, 2'd3, 0, 1, 4'b1001, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 1, 1, 4'b1001, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 1, 1, 4'b0001, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 1, 1, 4'b0001, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 1, 1, 4'b0001, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd3, 0, 1, 4'b0001, 1));
    vq.push_back(mk(0, 4'b0000, 2'd3, 2'd0, 0, 1, 4'b0001, 0));
    vq.push_back(mk(0, 4'b0000, 2'd2, 2'd0, 0, 1, 4'b0001, 0));
    vq.push_back(mk(0, 4'b0000, 2'd1, 2'd0, 0, 1, 4'b0001, 0));
    vq.push_back(mk(0, 4'b0000, 2'd0, 2'd0, 1, 1, 4'b0001, 0));
    vq.push_back(mk(0, 4'b0000, 2'd0, 2'd0, 1, 1, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 2'd0, 2'd0, 1, 1, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 2'd0, 2'd0, 1, 1, 4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 2'd0, 2'd0, 0, 0, 4'b0000, 0));

    foreach (vq[k]) begin
      rst = vq[k].rst;
      req = vq[k].req;
      cf  = vq[k].cf;
      step();
      check($sformatf("vec%0d {floor,door,busy,pend,dir}", k), outs(),
            {23'd0, vq[k].floor, vq[k].door, vq[k].busy, vq[k].pend, vq[k].dir});
    end

    // Retarget: heading 0->3, a call at 2 appears while passing floor 1.
    req = 4'b1000; cf = 2'd0; step();
    req = 4'b0000; step();
    check("rt_floor3", 32'(floor), 32'd3);
    check("rt_dir_up", 32'(dir), 32'd1);
    cf = 2'd1; step();
    req = 4'b0100; step();
    check("rt_pend", 32'(pending), 32'hC);
    req = 4'b0000; step();
    check("rt_floor2", 32'(floor), 32'd2);
    cf = 2'd2; step();
    check("rt_door_at2", 32'(door_open), 32'd1);
    dwell_cnt = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!door_open) break;
      dwell_cnt++;
    end
    check("rt_dwell_len", 32'(dwell_cnt), 32'd4);
    check("rt_pend_after", 32'(pending), 32'h8);
    step();
    check("rt_back_to3", 32'(floor), 32'd3);
    check("rt_dir_still_up", 32'(dir), 32'd1);

    // Held button at the open door.
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b0100; cf = 2'd2; step();
    req = 4'b0000; step();
    check("hb_floor2", 32'(floor), 32'd2);
    step();
    check("hb_door", 32'(door_open), 32'd1);
    req = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("hb_pend_hold%0d", k), 32'(pending), 32'h2);
      if (!door_open) break;
    end
    check("hb_door_closed", 32'(door_open), 32'd0);
    req = 4'b0000; step();
    check("hb_next_floor1", 32'(floor), 32'd1);
    check("hb_dir_down", 32'(dir), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hb_no_redwell%0d", k), 32'(door_open), 32'd0);
    end

    // Reset while the door is open.
    cf = 2'd1; step();
    check("rd_door", 32'(door_open), 32'd1);
    check("rd_pend", 32'(pending), 32'h2);
    rst = 1'b1; step();
    check("rd_after_rst", {29'd0, door_open, busy, (pending != 4'd0)}, 32'd0);
    check("rd_floor_rst", 32'(floor), 32'd0);
    rst = 1'b0; step();
    check("rd_idle", {30'd0, door_open, busy}, 32'd0);
    check("rd_idle_floor", 32'(floor), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
